ecc_scrub_ctrl: RTL and testbench

//  Access controller for the Hamming-protected 256x8 SRAM. Arbitrates a host port against a

---
 rtl/ecc_ctrl_pkg.sv | 18 +
 rtl/ecc_scrub_ctrl_timer.sv | 49 ++++
 rtl/ecc_scrub_ctrl.sv | 154 +++++++++++++++
 tb/tb_ecc_scrub_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_ctrl_pkg.sv
// Shared types and default sizing for the ECC scrub access controller.
package ecc_ctrl_pkg;

  localparam int ADDR_W_DEF         = 8;
  localparam int DATA_W_DEF         = 8;
  localparam int SCRUB_INTERVAL_DEF = 1024;
  localparam int MAX_DEFER_DEF      = 16;
  localparam int CNT_W_DEF          = 16;

  // IDLE serves the host or issues a scrub read; SCR_RD samples the decoder;
  // SCR_WB writes the corrected word back.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCR_RD = 2'd1,
    SCR_WB = 2'd2
  } state_t;

endpackage

// File: rtl/ecc_scrub_ctrl_timer.sv
// Scrub pacing: interval timer, pending-step flag and host deferral counter.
// force_scrub means the pending step has yielded to the host long enough.
module scrub_timer #(
  parameter int SCRUB_INTERVAL = 1024,
  parameter int MAX_DEFER      = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic scrub_en,
  input  logic host_grant,
  input  logic scrub_issue,
  output logic pending,
  output logic force_scrub
);

  localparam int TW = (SCRUB_INTERVAL > 2) ? $clog2(SCRUB_INTERVAL) : 1;
  localparam int DW = $clog2(MAX_DEFER + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(SCRUB_INTERVAL - 1);
  localparam logic [DW-1:0] DEFER_MAX  = DW'(MAX_DEFER);

  logic [TW-1:0] timer;
  logic [DW-1:0] defer;

  // Timer reload sets pending (a set wins over a same-cycle issue so no step is lost);
  // defer counts host grants made while a step waits.
  always_ff @(posedge clk) begin
    if (rst || !scrub_en) begin
      timer   <= '0;
      pending <= 1'b0;
      defer   <= '0;
    end else begin
      if (timer == TIMER_LAST) begin
        timer   <= '0;
        pending <= 1'b1;
      end else begin
        timer <= timer + 1'b1;
        if (scrub_issue) pending <= 1'b0;
      end
      if (scrub_issue) begin
        defer <= '0;
      end else if (pending && host_grant && defer != DEFER_MAX) begin
        defer <= defer + 1'b1;
      end
    end
  end

  assign force_scrub = pending && (defer == DEFER_MAX);

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// Arbitrates host accesses against a background scrubber for a Hamming-protected
// SRAM; corrects single-bit errors by write-back and counts ECC events.
module ecc_scrub_ctrl
  import ecc_ctrl_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int SCRUB_INTERVAL = SCRUB_INTERVAL_DEF,
  parameter int MAX_DEFER      = MAX_DEFER_DEF,
  parameter int CNT_W          = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rerr,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_err_corr,
  input  logic              mem_err_uncorr,
  input  logic              scrub_en,
  output logic              scrub_wrap,
  output logic              err_valid,
  output logic [ADDR_W-1:0] err_addr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt,
  output state_t            dbg_state,
  output logic [ADDR_W-1:0] dbg_scrub_addr
);

  // Host handshake: host_req is held with stable we/addr/wdata until host_gnt;
  // the access happens in the cycle where host_req && host_gnt, and a read answers
  // with a one-cycle host_rvalid pulse in the following cycle.

  state_t            state, state_next;
  logic [ADDR_W-1:0] scrub_addr;
  logic [DATA_W-1:0] wb_data;
  logic              rd_pend;
  logic              pending, force_scrub, scrub_issue;
  logic              step_done, scrub_uncorr, uncorr_hit;

  scrub_timer #(
    .SCRUB_INTERVAL(SCRUB_INTERVAL),
    .MAX_DEFER     (MAX_DEFER)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .scrub_en   (scrub_en),
    .host_grant (host_gnt),
    .scrub_issue(scrub_issue),
    .pending    (pending),
    .force_scrub(force_scrub)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state, grant and SRAM command; everything is held quiet while in reset.
  always_comb begin
    state_next  = state;
    host_gnt    = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    scrub_issue = 1'b0;
    case (state)
      IDLE: begin
        if (host_req && !force_scrub) begin
          host_gnt  = 1'b1;
          mem_en    = 1'b1;
          mem_we    = host_we;
          mem_addr  = host_addr;
          mem_wdata = host_wdata;
        end else if (pending) begin
          mem_en      = 1'b1;
          mem_addr    = scrub_addr;
          scrub_issue = 1'b1;
          state_next  = SCR_RD;
        end
      end
      SCR_RD: state_next = mem_err_corr ? SCR_WB : IDLE;
      SCR_WB: begin
        mem_en     = 1'b1;
        mem_we     = 1'b1;
        mem_addr   = scrub_addr;
        mem_wdata  = wb_data;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (rst) begin
      state_next  = IDLE;
      host_gnt    = 1'b0;
      mem_en      = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      scrub_issue = 1'b0;
    end
  end

  assign step_done    = ((state == SCR_RD) && !mem_err_corr) || (state == SCR_WB);
  assign scrub_uncorr = (state == SCR_RD) && !mem_err_corr && mem_err_uncorr;
  // A host read response can never coincide with SCR_RD, so one increment per cycle suffices.
  assign uncorr_hit   = scrub_uncorr || (rd_pend && mem_err_uncorr);

  // Scrub pointer, write-back capture, event pulses and saturating counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      scrub_addr <= '0;
      wb_data    <= '0;
      rd_pend    <= 1'b0;
      err_valid  <= 1'b0;
      err_addr   <= '0;
      scrub_wrap <= 1'b0;
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else begin
      rd_pend    <= host_gnt && !host_we;
      err_valid  <= 1'b0;
      scrub_wrap <= 1'b0;
      if ((state == SCR_RD) && mem_err_corr) wb_data <= mem_rdata;
      if (step_done) begin
        scrub_addr <= scrub_addr + 1'b1;
        scrub_wrap <= (scrub_addr == '1);
      end
      if (scrub_uncorr) begin
        err_valid <= 1'b1;
        err_addr  <= scrub_addr;
      end
      if ((state == SCR_WB) && (corr_cnt != '1)) corr_cnt <= corr_cnt + 1'b1;
      if (uncorr_hit && (uncorr_cnt != '1)) uncorr_cnt <= uncorr_cnt + 1'b1;
    end
  end

  assign host_rvalid    = rd_pend;
  assign host_rdata     = rd_pend ? mem_rdata : '0;
  assign host_rerr      = rd_pend && mem_err_uncorr;
  assign dbg_state      = state;
  assign dbg_scrub_addr = scrub_addr;

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Bench for ecc_scrub_ctrl: behavioural SRAM with injectable ECC faults, a golden
// data array, and a negedge monitor that scores host reads, scrub reads, write-backs
// and error reports against expectations pushed into queues.
module tb_ecc_scrub_ctrl;
  import ecc_ctrl_pkg::*;

  localparam int ADDR_W = 8, DATA_W = 8, DEPTH = 256;
  localparam int SCRUB_INTERVAL = 4, MAX_DEFER = 16, CNT_W = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              host_req, host_we, host_gnt, host_rvalid, host_rerr;
  logic [ADDR_W-1:0] host_addr, mem_addr, err_addr, dbg_scrub_addr;
  logic [DATA_W-1:0] host_wdata, host_rdata, mem_wdata, mem_rdata;
  logic              mem_en, mem_we, mem_err_corr, mem_err_uncorr;
  logic              scrub_en, scrub_wrap, err_valid;
  logic [CNT_W-1:0]  corr_cnt, uncorr_cnt;
  state_t            dbg_state;

  ecc_scrub_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SCRUB_INTERVAL(SCRUB_INTERVAL),
    .MAX_DEFER(MAX_DEFER), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata), .host_rerr(host_rerr),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_err_corr(mem_err_corr), .mem_err_uncorr(mem_err_uncorr),
    .scrub_en(scrub_en), .scrub_wrap(scrub_wrap), .err_valid(err_valid), .err_addr(err_addr),
    .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt),
    .dbg_state(dbg_state), .dbg_scrub_addr(dbg_scrub_addr)
  );

  // SRAM model: stores true data plus a fault tag (0 clean, 1 correctable, 2 uncorrectable).
  logic [DATA_W-1:0] sram_data [DEPTH];
  logic [1:0]        sram_flt  [DEPTH];
  logic              mem_clr, inj_en;
  logic [ADDR_W-1:0] inj_addr;
  logic [1:0]        inj_type;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        sram_data[i] <= '0;
        sram_flt[i]  <= '0;
      end
      mem_rdata      <= '0;
      mem_err_corr   <= 1'b0;
      mem_err_uncorr <= 1'b0;
    end else begin
      mem_err_corr   <= 1'b0;
      mem_err_uncorr <= 1'b0;
      if (inj_en) sram_flt[inj_addr] <= inj_type;
      if (mem_en && mem_we) begin
        sram_data[mem_addr] <= mem_wdata;
        sram_flt[mem_addr]  <= 2'd0;
      end else if (mem_en) begin
        mem_rdata      <= (sram_flt[mem_addr] == 2'd2) ? (sram_data[mem_addr] ^ 8'hA5)
                                                       : sram_data[mem_addr];
        mem_err_corr   <= (sram_flt[mem_addr] == 2'd1);
        mem_err_uncorr <= (sram_flt[mem_addr] == 2'd2);
      end
    end
  end

  // scoreboard state
  int tests = 0, fails = 0, cyc = 0;
  logic [DATA_W-1:0] gold [DEPTH];
  logic [24:0]       rd_q[$];   // {due cycle, rerr, data}
  logic [15:0]       wb_q[$];   // {addr, data}
  logic [7:0]        err_q[$];  // addr
  logic [ADDR_W-1:0] exp_scrub;
  int m_steps = 0, m_corr = 0, m_uncorr = 0, wraps = 0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pushes expectations on DUT commands and pops them on DUT responses.
  always @(negedge clk) begin
    logic [24:0] e;
    logic [15:0] w;
    logic        f;
    cyc++;
    if (rst) begin
      rd_q.delete(); wb_q.delete(); err_q.delete();
      exp_scrub = '0; m_steps = 0; m_corr = 0; m_uncorr = 0; wraps = 0;
    end else begin
      if (host_rvalid) begin
        check_eq("rd_expected", 32'(rd_q.size() > 0), 32'd1);
        if (rd_q.size() > 0) begin
          e = rd_q.pop_front();
          check_eq("rd_latency", 32'(cyc[15:0]), 32'(e[24:9]));
          check_eq("rd_data", 32'(host_rdata), 32'(e[7:0]));
          check_eq("rd_err", 32'(host_rerr), 32'(e[8]));
        end
      end
      if (host_gnt) begin
        check_eq("gnt_route", 32'({mem_en, mem_we, mem_addr}), 32'({1'b1, host_we, host_addr}));
        if (host_we) begin
          check_eq("gnt_wdata", 32'(mem_wdata), 32'(host_wdata));
        end else begin
          f = (sram_flt[host_addr] == 2'd2);
          rd_q.push_back({cyc[15:0] + 16'd1, f, gold[host_addr] ^ (f ? 8'hA5 : 8'h00)});
          if (f) m_uncorr++;
        end
      end else if (mem_en && !mem_we) begin
        check_eq("scrub_rd_addr", 32'(mem_addr), 32'(exp_scrub));
        if (sram_flt[mem_addr] == 2'd1) begin
          wb_q.push_back({mem_addr, gold[mem_addr]});
          m_corr++;
        end else if (sram_flt[mem_addr] == 2'd2) begin
          err_q.push_back(mem_addr);
          m_uncorr++;
        end
        exp_scrub = exp_scrub + 1'b1;
        m_steps++;
      end else if (mem_en && mem_we) begin
        check_eq("wb_expected", 32'(wb_q.size() > 0), 32'd1);
        if (wb_q.size() > 0) begin
          w = wb_q.pop_front();
          check_eq("wb_addr_data", 32'({mem_addr, mem_wdata}), 32'(w));
        end
      end
      if (err_valid) begin
        check_eq("err_expected", 32'(err_q.size() > 0), 32'd1);
        if (err_q.size() > 0) check_eq("err_addr", 32'(err_addr), 32'(err_q.pop_front()));
      end
      if (scrub_wrap) wraps++;
    end
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic host_op(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int n;
    bit got;
    n = 0; got = 0;
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    while (!got && n < 50) begin
      @(negedge clk);
      n++;
      got = host_gnt;
    end
    if (!got) check_eq("gnt_timeout", 32'(got), 32'd1);
    if (got && we) gold[a] = d;
    @(posedge clk); #1;
    host_req = 1'b0;
  endtask

  task automatic inject(input logic [ADDR_W-1:0] a, input logic [1:0] t);
    inj_en = 1'b1; inj_addr = a; inj_type = t;
    @(posedge clk); #1;
    inj_en = 1'b0;
  endtask

  task automatic sweep_until(input int target_steps);
    int start;
    start = cyc;
    scrub_en = 1'b1;
    while (m_steps < target_steps && (cyc - start) < 8000) begin
      if ($urandom_range(0, 1) == 1)
        host_op(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      else
        idle(1);
    end
    scrub_en = 1'b0;
    idle(6);
    check_eq("sweep_done", 32'(m_steps >= target_steps), 32'd1);
  endtask

  initial begin
    int  m_corr_before, lead, lows, idx, t6_addr;
    bit  found;
    logic g [SCRUB_INTERVAL + MAX_DEFER + 6];

    rst = 1'b1; mem_clr = 1'b1; inj_en = 1'b0; inj_addr = '0; inj_type = '0;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'd3; host_wdata = 8'h11; scrub_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) gold[i] = '0;
    idle(3);
    mem_clr = 1'b0;
    @(negedge clk);
    // reset state with a host request pending: nothing may be granted or driven
    check_eq("rst_gnt", 32'(host_gnt), 32'd0);
    check_eq("rst_mem_en", 32'({mem_en, mem_we}), 32'd0);
    check_eq("rst_rvalid", 32'(host_rvalid), 32'd0);
    check_eq("rst_cnts", 32'({corr_cnt, uncorr_cnt}), 32'd0);
    check_eq("rst_pulses", 32'({err_valid, scrub_wrap, err_addr}), 32'd0);
    check_eq("rst_state", 32'({dbg_state, dbg_scrub_addr}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; host_req = 1'b0;

    // 1: write then read back with scrubbing off
    host_op(1'b1, 8'd10, 8'h2C);
    host_op(1'b0, 8'd10, 8'h00);
    @(negedge clk);
    check_eq("t1_rvalid", 32'(host_rvalid), 32'd1);
    check_eq("t1_rdata", 32'({host_rerr, host_rdata}), 32'h02C);
    @(posedge clk); #1;
    for (int i = 0; i < 60; i++)
      host_op(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    idle(2);

    // 2/3: single-bit faults (addr 0 and a few others), double-bit at addr 20
    inject(8'd0, 2'd1);
    for (int i = 0; i < 5; i++) inject(8'($urandom_range(30, 250)), 2'd1);
    inject(8'd20, 2'd2);
    sweep_until(DEPTH);
    check_eq("t2_addr0_clean", 32'(sram_flt[0]), 32'd0);
    check_eq("t2_addr0_data", 32'(sram_data[0]), 32'(gold[0]));
    check_eq("t2_corr_cnt", 32'(corr_cnt), 32'(m_corr));
    check_eq("t3_uncorr_cnt", 32'(uncorr_cnt), 32'(m_uncorr));
    check_eq("t5_wraps", 32'(wraps), 32'(m_steps / DEPTH));
    check_eq("t5_scrub_addr", 32'(dbg_scrub_addr), 32'(m_steps % DEPTH));

    // 5: second sweep over memory with no correctable faults left
    m_corr_before = m_corr;
    sweep_until(2 * DEPTH);
    check_eq("t5_clean_corr", 32'(corr_cnt), 32'(m_corr_before));
    check_eq("t5_uncorr_cnt", 32'(uncorr_cnt), 32'(m_uncorr));
    check_eq("t5_wraps2", 32'(wraps), 32'(m_steps / DEPTH));
    check_eq("t5_scrub_addr2", 32'(dbg_scrub_addr), 32'(m_steps % DEPTH));

    // 4: continuous host reads; scrub pending after SCRUB_INTERVAL cycles, then wins after
    // MAX_DEFER more grants and blocks the host for exactly two cycles
    idle(4);
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'($urandom_range(0, 255)); scrub_en = 1'b1;
    for (int i = 0; i < SCRUB_INTERVAL + MAX_DEFER + 6; i++) begin
      @(negedge clk);
      g[i] = host_gnt;
      @(posedge clk); #1;
      host_addr = 8'($urandom_range(0, 255));
    end
    host_req = 1'b0; scrub_en = 1'b0;
    lead = 0;
    while (lead < SCRUB_INTERVAL + MAX_DEFER + 6 && g[lead]) lead++;
    lows = 0; idx = lead;
    while (idx < SCRUB_INTERVAL + MAX_DEFER + 6 && !g[idx]) begin lows++; idx++; end
    check_eq("t4_grants_before_scrub", 32'(lead), 32'(SCRUB_INTERVAL + MAX_DEFER));
    check_eq("t4_stall_cycles", 32'(lows), 32'd2);
    idle(6);
    check_eq("t4_uncorr_cnt", 32'(uncorr_cnt), 32'(m_uncorr));

    // 6: reset while the scrubber is reading a correctable word
    t6_addr = int'(exp_scrub);
    inject(exp_scrub, 2'd1);
    scrub_en = 1'b1;
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(posedge clk); #1;
      found = (dbg_state == SCR_RD);
    end
    check_eq("t6_reached_rd", 32'(found), 32'd1);
    rst = 1'b1; scrub_en = 1'b0;
    @(negedge clk);
    check_eq("t6_no_we_in_rst", 32'({mem_en, mem_we}), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("t6_state", 32'({dbg_state, dbg_scrub_addr}), 32'd0);
    check_eq("t6_outputs", 32'({host_rvalid, err_valid, scrub_wrap, corr_cnt, uncorr_cnt}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(8);
    check_eq("t6_no_writeback", 32'(sram_flt[t6_addr]), 32'd1);
    check_eq("t6_corr_cnt", 32'(corr_cnt), 32'd0);

    // final report
    check_eq("final_rd_q", 32'(rd_q.size()), 32'd0);
    check_eq("final_wb_q", 32'(wb_q.size()), 32'd0);
    check_eq("final_err_q", 32'(err_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
